// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Multi-cycle hardwired control unit for the RISC datapath. Walks each
//   instruction through fetch (F0..F2), decode (DEC) and an opcode-specific
//   execute sequence. It drives the datapath register strobes and the ALU
//   op-select, and runs the memory read/write handshake.
//
// Ports
//   clock      : system clock, rising edge
//   clear      : asynchronous active-low reset (returns to IDLE at once)
//   ir         : IR contents [31:27] opc, [26:23] Ra, [22:19] Rb, [18:15] Rc
//   mem_ready  : memory completes the pending read/write at this edge
//   pco/pci/pc_inc, iri/iro, mari/maro, mdri/mdro/mdr_sel, ryi/rzi/rzo,
//   cout, gpr_in/gpr_out/gpr_sel, alu_op : datapath controls
//   mem_read/mem_write : memory request, held until mem_ready
//   halted     : high while in HALT
//   illegal    : one-cycle pulse in DEC for an undefined opcode
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int unsigned REG_BITS   = 4,
    parameter logic [4:0]  ALU_ADD_OP = 5'd3
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                pco,
    output logic                pci,
    output logic                pc_inc,
    output logic                iri,
    output logic                iro,
    output logic                mari,
    output logic                maro,
    output logic                mdri,
    output logic                mdro,
    output logic                mdr_sel,
    output logic                ryi,
    output logic                rzi,
    output logic                rzo,
    output logic                cout,
    output logic                gpr_in,
    output logic                gpr_out,
    output logic [REG_BITS-1:0] gpr_sel,
    output logic [4:0]          alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [3:0] {
        IDLE, F0, F1, F2, DEC,
        A3, A4, A5,
        E3, E4, E5,
        L6, L7, S6, S7,
        HALT
    } state_t;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_ST   = 5'b00001;
    localparam logic [4:0] OPC_ALU0 = 5'b00010;
    localparam logic [4:0] OPC_ALU1 = 5'b01011;
    localparam logic [4:0] OPC_NOP  = 5'b11000;
    localparam logic [4:0] OPC_HALT = 5'b11001;

    state_t state;
    state_t state_nxt;

    logic [4:0]          opc;
    logic [REG_BITS-1:0] ra;
    logic [REG_BITS-1:0] rb;
    logic [REG_BITS-1:0] rc;
    logic                is_alu;

    // The immediate field is consumed by the datapath, not by the sequencer.
    logic unused_ir;

    assign opc       = ir[31:27];
    assign ra        = ir[26 -: REG_BITS];
    assign rb        = ir[22 -: REG_BITS];
    assign rc        = ir[18 -: REG_BITS];
    assign is_alu    = (opc >= OPC_ALU0) && (opc <= OPC_ALU1);
    assign unused_ir = ^ir[14:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pco       = 1'b0;
        pci       = 1'b0;
        pc_inc    = 1'b0;
        iri       = 1'b0;
        iro       = 1'b0;
        mari      = 1'b0;
        maro      = 1'b0;
        mdri      = 1'b0;
        mdro      = 1'b0;
        mdr_sel   = 1'b0;
        ryi       = 1'b0;
        rzi       = 1'b0;
        rzo       = 1'b0;
        cout      = 1'b0;
        gpr_in    = 1'b0;
        gpr_out   = 1'b0;
        gpr_sel   = '0;
        alu_op    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;

        case (state)
            IDLE: state_nxt = F0;

            F0: begin
                pco       = 1'b1;
                mari      = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = F1;
            end

            // MDR captures memory data only on the edge the read completes.
            F1: begin
                mem_read = 1'b1;
                mdr_sel  = 1'b1;
                mdri     = mem_ready;
                if (mem_ready) state_nxt = F2;
            end

            F2: begin
                mdro      = 1'b1;
                iri       = 1'b1;
                state_nxt = DEC;
            end

            DEC: begin
                if (opc == OPC_LD || opc == OPC_ST) begin
                    state_nxt = E3;
                end else if (is_alu) begin
                    state_nxt = A3;
                end else if (opc == OPC_HALT) begin
                    state_nxt = HALT;
                end else begin
                    // Undefined opcodes flag once and then behave as NOP.
                    illegal   = (opc != OPC_NOP);
                    state_nxt = F0;
                end
            end

            // The ALU op-select is held across the whole ALU sequence.
            A3: begin
                gpr_out   = 1'b1;
                gpr_sel   = rb;
                ryi       = 1'b1;
                alu_op    = opc;
                state_nxt = A4;
            end

            A4: begin
                gpr_out   = 1'b1;
                gpr_sel   = rc;
                rzi       = 1'b1;
                alu_op    = opc;
                state_nxt = A5;
            end

            A5: begin
                rzo       = 1'b1;
                gpr_in    = 1'b1;
                gpr_sel   = ra;
                alu_op    = opc;
                state_nxt = F0;
            end

            E3: begin
                gpr_out   = 1'b1;
                gpr_sel   = rb;
                ryi       = 1'b1;
                state_nxt = E4;
            end

            E4: begin
                cout      = 1'b1;
                alu_op    = ALU_ADD_OP;
                rzi       = 1'b1;
                state_nxt = E5;
            end

            E5: begin
                rzo       = 1'b1;
                mari      = 1'b1;
                state_nxt = (opc == OPC_LD) ? L6 : S6;
            end

            L6: begin
                mem_read = 1'b1;
                mdr_sel  = 1'b1;
                mdri     = mem_ready;
                if (mem_ready) state_nxt = L7;
            end

            L7: begin
                mdro      = 1'b1;
                gpr_in    = 1'b1;
                gpr_sel   = ra;
                state_nxt = F0;
            end

            // Store data comes from the bus, so the MDR mux selects bus.
            S6: begin
                gpr_out   = 1'b1;
                gpr_sel   = ra;
                mdri      = 1'b1;
                state_nxt = S7;
            end

            S7: begin
                mem_write = 1'b1;
                if (mem_ready) state_nxt = F0;
            end

            HALT: halted = 1'b1;

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//   Self-checking bench for control_sequencer. A reference model expands each
//   instruction into the expected per-cycle control vector (plus the
//   mem_ready value to drive that cycle) from the instruction-level rules;
//   each test task compares the DUT against that expectation.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ready;
    logic        pco, pci, pc_inc, iri, iro, mari, maro, mdri, mdro, mdr_sel;
    logic        ryi, rzi, rzo, cout, gpr_in, gpr_out;
    logic [3:0]  gpr_sel;
    logic [4:0]  alu_op;
    logic        mem_read, mem_write, halted, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    control_sequencer #(.REG_BITS(4), .ALU_ADD_OP(5'd3)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .pco(pco), .pci(pci), .pc_inc(pc_inc), .iri(iri), .iro(iro),
        .mari(mari), .maro(maro), .mdri(mdri), .mdro(mdro), .mdr_sel(mdr_sel),
        .ryi(ryi), .rzi(rzi), .rzo(rzo), .cout(cout),
        .gpr_in(gpr_in), .gpr_out(gpr_out), .gpr_sel(gpr_sel), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .halted(halted), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary expected summary");
        $fatal(1, "simulation time limit");
    end

    // Control vector bit positions; gpr_sel at [23:20], alu_op at [28:24].
    localparam int B_PCO = 0,  B_PCI = 1,  B_PCINC = 2, B_IRI = 3,  B_IRO = 4;
    localparam int B_MARI = 5, B_MARO = 6, B_MDRI = 7,  B_MDRO = 8, B_MDRSEL = 9;
    localparam int B_RYI = 10, B_RZI = 11, B_RZO = 12,  B_COUT = 13;
    localparam int B_GIN = 14, B_GOUT = 15, B_MRD = 16, B_MWR = 17;
    localparam int B_HALT = 18, B_ILL = 19;

    typedef struct {
        logic [28:0] vec;
        bit          rdy;
        logic [31:0] ir;
    } step_t;

    step_t exp_q[$];

    function automatic logic [28:0] b(int n);
        return 29'(1) << n;
    endfunction

    function automatic logic [28:0] gs(logic [3:0] r);
        return {5'b0, r, 20'b0};
    endfunction

    function automatic logic [28:0] ao(logic [4:0] o);
        return {o, 24'b0};
    endfunction

    function automatic logic [28:0] obs_vec();
        logic [28:0] v;
        v = '0;
        v[B_PCO] = pco;   v[B_PCI] = pci;   v[B_PCINC] = pc_inc;
        v[B_IRI] = iri;   v[B_IRO] = iro;   v[B_MARI] = mari;  v[B_MARO] = maro;
        v[B_MDRI] = mdri; v[B_MDRO] = mdro; v[B_MDRSEL] = mdr_sel;
        v[B_RYI] = ryi;   v[B_RZI] = rzi;   v[B_RZO] = rzo;    v[B_COUT] = cout;
        v[B_GIN] = gpr_in; v[B_GOUT] = gpr_out;
        v[B_MRD] = mem_read; v[B_MWR] = mem_write;
        v[B_HALT] = halted; v[B_ILL] = illegal;
        v[23:20] = gpr_sel;
        v[28:24] = alu_op;
        return v;
    endfunction

    task automatic push(input logic [28:0] v, input bit r, input logic [31:0] i);
        step_t s;
        s.vec = v;
        s.rdy = r;
        s.ir  = i;
        exp_q.push_back(s);
    endtask

    // mem_ready is a don't-care outside memory waits, so it is randomised.
    task automatic push_free(input logic [28:0] v, input logic [31:0] i);
        push(v, ($urandom_range(0, 1) == 1), i);
    endtask

    task automatic push_mem(input logic [28:0] base, input logic [28:0] done_extra,
                            input int waits, input logic [31:0] i);
        for (int w = 0; w < waits; w++) push(base, 1'b0, i);
        push(base | done_extra, 1'b1, i);
    endtask

    // Reference model: one instruction starting at F0. HALT stops after DEC.
    task automatic model_instr(input logic [31:0] i, input int fw, input int mw);
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        bit         legal, alu;
        opc   = i[31:27];
        ra    = i[26:23];
        rb    = i[22:19];
        rc    = i[18:15];
        alu   = (opc >= 2) && (opc <= 11);
        legal = (opc <= 1) || alu || (opc == 24) || (opc == 25);

        push_free(b(B_PCO) | b(B_MARI) | b(B_PCINC), i);
        push_mem(b(B_MRD) | b(B_MDRSEL), b(B_MDRI), fw, i);
        push_free(b(B_MDRO) | b(B_IRI), i);
        push_free(legal ? 29'd0 : b(B_ILL), i);

        if (alu) begin
            push_free(b(B_GOUT) | gs(rb) | b(B_RYI) | ao(opc), i);
            push_free(b(B_GOUT) | gs(rc) | b(B_RZI) | ao(opc), i);
            push_free(b(B_RZO) | b(B_GIN) | gs(ra) | ao(opc), i);
        end else if (opc <= 1) begin
            push_free(b(B_GOUT) | gs(rb) | b(B_RYI), i);
            push_free(b(B_COUT) | ao(5'd3) | b(B_RZI), i);
            push_free(b(B_RZO) | b(B_MARI), i);
            if (opc == 0) begin
                push_mem(b(B_MRD) | b(B_MDRSEL), b(B_MDRI), mw, i);
                push_free(b(B_MDRO) | b(B_GIN) | gs(ra), i);
            end else begin
                push_free(b(B_GOUT) | gs(ra) | b(B_MDRI), i);
                push_mem(b(B_MWR), 29'd0, mw, i);
            end
        end
    endtask

    // Drive one cycle's inputs after the edge, sample at the falling edge.
    task automatic cycle(input step_t s, output logic [28:0] obs);
        @(posedge clock);
        #1;
        mem_ready = s.rdy;
        ir        = s.ir;
        @(negedge clock);
        obs = obs_vec();
    endtask

    // Leaves the DUT in its IDLE cycle; the next cycle() call observes F0.
    task automatic apply_reset();
        clear     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [28:0] obs;
        step_t       s;
        clear     = 1'b0;
        mem_ready = 1'b1;
        ir        = 32'h1888_8000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if (obs_vec() !== 29'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %h expected %h", k, obs_vec(), 29'd0);
            end
        end
        @(posedge clock);
        #1;
        clear = 1'b1;
        @(negedge clock);
        n_checks++;
        if (obs_vec() !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), 29'd0);
        end
        s.vec = b(B_PCO) | b(B_MARI) | b(B_PCINC);
        s.rdy = 1'b0;
        s.ir  = 32'h1888_8000;
        cycle(s, obs);
        n_checks++;
        if (obs !== s.vec) begin
            n_fail++;
            $display("FAIL reset_f0: got %h expected %h", obs, s.vec);
        end
    endtask

    task automatic test_add();
        logic [28:0] obs;
        apply_reset();
        model_instr(32'h1888_8000, 0, 0);
        push_free(b(B_PCO) | b(B_MARI) | b(B_PCINC), 32'h0);
        // exp_q[0] is cycle 1; DEC is cycle 4, A5 cycle 7, F0 again cycle 8.
        for (int k = 0; k < exp_q.size(); k++) begin
            cycle(exp_q[k], obs);
            n_checks++;
            if (obs !== exp_q[k].vec) begin
                n_fail++;
                $display("FAIL add cyc %0d: got %h expected %h", k + 1, obs, exp_q[k].vec);
            end
        end
    endtask

    task automatic test_fetch_wait();
        logic [28:0] obs;
        int n_rd, n_mdri, mdri_at, iri_at;
        n_rd = 0; n_mdri = 0; mdri_at = -1; iri_at = -1;
        apply_reset();
        model_instr(32'h1888_8000, 3, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            cycle(exp_q[k], obs);
            if (obs[B_MRD]) n_rd++;
            if (obs[B_MDRI]) begin n_mdri++; mdri_at = k; end
            if (obs[B_IRI]) iri_at = k;
            n_checks++;
            if (obs !== exp_q[k].vec) begin
                n_fail++;
                $display("FAIL fetch_wait cyc %0d: got %h expected %h", k, obs, exp_q[k].vec);
            end
        end
        n_checks++;
        if (n_rd !== 4) begin
            n_fail++;
            $display("FAIL fetch_wait_rd_cycles: got %0d expected %0d", n_rd, 4);
        end
        n_checks++;
        if (n_mdri !== 1 || mdri_at !== 4 || iri_at !== 5) begin
            n_fail++;
            $display("FAIL fetch_wait_mdri_iri: got mdri=%0d@%0d iri@%0d expected 1@4 iri@5",
                     n_mdri, mdri_at, iri_at);
        end
    endtask

    task automatic test_load();
        logic [28:0] obs;
        apply_reset();
        model_instr(32'h0110_0010, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            cycle(exp_q[k], obs);
            n_checks++;
            if (obs !== exp_q[k].vec) begin
                n_fail++;
                $display("FAIL load cyc %0d: got %h expected %h", k, obs, exp_q[k].vec);
            end
        end
        n_checks++;
        if (exp_q.size() !== 9) begin
            n_fail++;
            $display("FAIL load_latency: got %0d expected %0d", exp_q.size(), 9);
        end
    endtask

    task automatic test_store();
        logic [28:0] obs;
        int n_wr, n_mdro_exec;
        n_wr = 0; n_mdro_exec = 0;
        apply_reset();
        model_instr(32'h09A0_0000, 0, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            cycle(exp_q[k], obs);
            if (obs[B_MWR]) n_wr++;
            if (k >= 3 && obs[B_MDRO]) n_mdro_exec++;
            n_checks++;
            if (obs !== exp_q[k].vec) begin
                n_fail++;
                $display("FAIL store cyc %0d: got %h expected %h", k, obs, exp_q[k].vec);
            end
        end
        n_checks++;
        if (n_wr !== 3 || n_mdro_exec !== 0) begin
            n_fail++;
            $display("FAIL store_counts: got wr=%0d mdro=%0d expected wr=3 mdro=0", n_wr, n_mdro_exec);
        end
    endtask

    task automatic test_illegal();
        logic [28:0] obs;
        int n_ill;
        n_ill = 0;
        apply_reset();
        model_instr(32'hF800_0000, 0, 0);
        push_free(b(B_PCO) | b(B_MARI) | b(B_PCINC), 32'h0);
        for (int k = 0; k < exp_q.size(); k++) begin
            cycle(exp_q[k], obs);
            if (obs[B_ILL]) n_ill++;
            n_checks++;
            if (obs !== exp_q[k].vec) begin
                n_fail++;
                $display("FAIL illegal cyc %0d: got %h expected %h", k, obs, exp_q[k].vec);
            end
        end
        n_checks++;
        if (n_ill !== 1) begin
            n_fail++;
            $display("FAIL illegal_pulse_len: got %0d expected %0d", n_ill, 1);
        end
    endtask

    task automatic test_halt();
        logic [28:0] obs;
        apply_reset();
        model_instr(32'hC800_0000, 1, 0);
        for (int k = 0; k < 20; k++) push_free(b(B_HALT), 32'hC800_0000);
        for (int k = 0; k < exp_q.size(); k++) begin
            cycle(exp_q[k], obs);
            n_checks++;
            if (obs !== exp_q[k].vec) begin
                n_fail++;
                $display("FAIL halt cyc %0d: got %h expected %h", k, obs, exp_q[k].vec);
            end
        end
    endtask

    task automatic test_clear_mid();
        logic [28:0] obs;
        step_t       s;
        apply_reset();
        model_instr(32'h0110_0010, 0, 5);
        // Entries 0..6 are F0..E5; entry 7 is the first L6 wait cycle.
        for (int k = 0; k < 8; k++) begin
            cycle(exp_q[k], obs);
            n_checks++;
            if (obs !== exp_q[k].vec) begin
                n_fail++;
                $display("FAIL clear_mid_pre cyc %0d: got %h expected %h", k, obs, exp_q[k].vec);
            end
        end
        #2;
        clear = 1'b0;
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || obs_vec() !== 29'd0) begin
            n_fail++;
            $display("FAIL clear_mid_drop: got rd=%b vec=%h expected rd=0 vec=0", mem_read, obs_vec());
        end
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        @(negedge clock);
        n_checks++;
        if (obs_vec() !== 29'd0) begin
            n_fail++;
            $display("FAIL clear_mid_idle: got %h expected %h", obs_vec(), 29'd0);
        end
        s.vec = b(B_PCO) | b(B_MARI) | b(B_PCINC);
        s.rdy = 1'b1;
        s.ir  = 32'h0;
        cycle(s, obs);
        n_checks++;
        if (obs !== s.vec) begin
            n_fail++;
            $display("FAIL clear_mid_restart: got %h expected %h", obs, s.vec);
        end
    endtask

    task automatic test_back_to_back();
        logic [28:0] obs;
        logic [31:0] i;
        logic [4:0]  opc;
        int          sel;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       opc = 5'd0;
                1:       opc = 5'd1;
                7:       opc = 5'd24;
                8:       opc = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(12, 23))
                                                           : 5'($urandom_range(26, 31));
                default: opc = 5'($urandom_range(2, 11));
            endcase
            i = {opc, 27'($urandom)};
            model_instr(i, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            cycle(exp_q[k], obs);
            n_checks++;
            if (obs !== exp_q[k].vec) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d ir %h: got %h expected %h",
                         k, exp_q[k].ir, obs, exp_q[k].vec);
            end
        end
    endtask

    initial begin
        clear     = 1'b0;
        ir        = 32'h0;
        mem_ready = 1'b0;
        test_reset();
        test_add();
        test_fetch_wait();
        test_load();
        test_store();
        test_illegal();
        test_halt();
        test_clear_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
